// File: rtl/ask_pkg.sv
// ask_pkg: shared constants, state encoding and frame helpers for the ASK
// receive path.
//   WORD_W / DATA_W : assembled word width and payload width
//   *_BIT, DATA_HI/LO: field positions inside the assembled word
//   state_e          : deframer lock state (HUNT=0, LOCKED=1)
package ask_pkg;

  localparam int unsigned WORD_W   = 12;
  localparam int unsigned DATA_W   = 8;
  localparam int unsigned ERR_W    = 8;

  localparam int unsigned MARK_BIT = 11;
  localparam int unsigned DATA_HI  = 10;
  localparam int unsigned DATA_LO  = 3;
  localparam int unsigned PAR_BIT  = 2;
  localparam int unsigned STOP_BIT = 1;
  localparam int unsigned PAD_BIT  = 0;

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } state_e;

  // Good frame: marker set, pad clear, stop set, even parity over the payload.
  function automatic logic frame_good(input logic [WORD_W-1:0] w);
    return w[MARK_BIT] & ~w[PAD_BIT] & w[STOP_BIT] &
           (w[PAR_BIT] == ^w[DATA_HI:DATA_LO]);
  endfunction

  // Payload field of an assembled word.
  function automatic logic [DATA_W-1:0] frame_payload(input logic [WORD_W-1:0] w);
    return w[DATA_HI:DATA_LO];
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with registered full/empty flags.
//   clk, rst  : clock, asynchronous active-high reset (flushes contents)
//   push_i    : write data_i; ignored when full unless pop_i frees a slot
//   pop_i     : remove head; ignored when empty
//   data_i    : write data
//   data_o    : head entry (reset contents are zero)
//   full_o    : DEPTH entries held
//   empty_o   : no entries held
// DEPTH must be a power of two, at least 2, so pointers wrap naturally.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic             wr_c, rd_c;

  // A pop in the same cycle frees the slot a full-FIFO push needs.
  always_comb begin
    wr_c     = push_i & (~full_q | pop_i);
    rd_c     = pop_i & ~empty_q;
    wr_ptr_d = wr_ptr_q + PTR_W'(wr_c);
    rd_ptr_d = rd_ptr_q + PTR_W'(rd_c);
    count_d  = count_q + CNT_W'(wr_c) - CNT_W'(rd_c);
    full_d   = (count_d == CNT_W'(DEPTH));
    empty_d  = (count_d == '0);
  end

  // Storage, pointers and flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      if (wr_c) mem_q[wr_ptr_q] <= data_i;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  assign data_o  = mem_q[rd_ptr_q];
  assign full_o  = full_q;
  assign empty_o = empty_q;

endmodule

// File: rtl/word_deframer.sv
// word_deframer: checks assembled ASK words, tracks frame lock and buffers
// payloads of good frames seen while locked.
//   clk, rst   : clock, asynchronous active-high reset
//   word_in    : assembled word, sampled when word_valid=1
//   word_valid : one-cycle strobe for word_in
//   out_data   : FIFO head payload
//   out_valid  : FIFO not empty
//   out_ready  : sink takes out_data this cycle when out_valid=1
//   locked     : state is LOCKED
//   frame_err  : registered pulse per bad frame
//   overflow   : registered pulse per payload dropped on a full FIFO
//   err_count  : saturating count of bad frames plus overflows
module word_deframer
  import ask_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned LOCK_COUNT = 2,
  parameter int unsigned LOSS_COUNT = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WORD_W-1:0] word_in,
  input  logic              word_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              locked,
  output logic              frame_err,
  output logic              overflow,
  output logic [ERR_W-1:0]  err_count
);

  localparam int unsigned GOOD_W = $clog2(LOCK_COUNT + 1);
  localparam int unsigned BAD_W  = $clog2(LOSS_COUNT + 1);

  state_e             state_q, state_d;
  logic [GOOD_W-1:0]  good_run_q, good_run_d;
  logic [BAD_W-1:0]   bad_run_q, bad_run_d;
  logic               frame_err_q, frame_err_d;
  logic               overflow_q, overflow_d;
  logic [ERR_W-1:0]   err_count_q, err_count_d;

  logic               good_c;
  logic               push_c;
  logic               pop_c;
  logic               fifo_full;
  logic               fifo_empty;

  assign good_c = frame_good(word_in);
  assign pop_c  = ~fifo_empty & out_ready;

  // Lock FSM, push decision and error accounting; only strobed words count.
  always_comb begin
    state_d     = state_q;
    good_run_d  = good_run_q;
    bad_run_d   = bad_run_q;
    frame_err_d = 1'b0;
    push_c      = 1'b0;

    if (word_valid) begin
      case (state_q)
        HUNT: begin
          if (good_c) begin
            // The frame that completes lock is not pushed.
            if (good_run_q == GOOD_W'(LOCK_COUNT - 1)) begin
              state_d    = LOCKED;
              good_run_d = '0;
            end else begin
              good_run_d = good_run_q + GOOD_W'(1);
            end
          end else begin
            good_run_d  = '0;
            frame_err_d = 1'b1;
          end
        end
        LOCKED: begin
          if (good_c) begin
            bad_run_d = '0;
            push_c    = 1'b1;
          end else begin
            frame_err_d = 1'b1;
            if (bad_run_q == BAD_W'(LOSS_COUNT - 1)) begin
              state_d   = HUNT;
              bad_run_d = '0;
            end else begin
              bad_run_d = bad_run_q + BAD_W'(1);
            end
          end
        end
      endcase
    end

    // A concurrent pop makes room, so only full-without-pop drops.
    overflow_d = push_c & fifo_full & ~pop_c;

    err_count_d = err_count_q;
    if ((frame_err_d | overflow_d) && (err_count_q != {ERR_W{1'b1}})) begin
      err_count_d = err_count_q + ERR_W'(1);
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= HUNT;
      good_run_q  <= '0;
      bad_run_q   <= '0;
      frame_err_q <= 1'b0;
      overflow_q  <= 1'b0;
      err_count_q <= '0;
    end else begin
      state_q     <= state_d;
      good_run_q  <= good_run_d;
      bad_run_q   <= bad_run_d;
      frame_err_q <= frame_err_d;
      overflow_q  <= overflow_d;
      err_count_q <= err_count_d;
    end
  end

  sync_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push_c),
    .pop_i   (pop_c),
    .data_i  (frame_payload(word_in)),
    .data_o  (out_data),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign out_valid = ~fifo_empty;
  assign locked    = (state_q == LOCKED);
  assign frame_err = frame_err_q;
  assign overflow  = overflow_q;
  assign err_count = err_count_q;

endmodule
